// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

    localparam int          FETCH_DEPTH_DEFAULT = 2;
    localparam logic [31:0] NOP                 = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched entries; flush empties it and overrides push/pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid && !flush;
    assign do_push    = push && (count != CNT_W'(DEPTH)) && !flush;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
                count <= count - CNT_W'(1);
        end
    end

    // storage needs no reset: outputs are gated by head_valid at the top level
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding an instruction buffer.
//   state | meaning
//   IDLE  | no request outstanding; issue when a buffer slot is free
//   REQ   | request presented, waiting for imem_gnt
//   WAIT  | request accepted, waiting for imem_rvalid
//   DROP  | flushed while accepted; discard the next imem_rvalid
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int FETCH_DEPTH = FETCH_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    input  logic        flush,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);

    localparam int CNT_W = $clog2(FETCH_DEPTH) + 1;

    fetch_state_t state, state_next;
    fetch_entry_t push_data;
    fetch_entry_t head;
    logic         push;
    logic         pop;
    logic         advance;
    logic         buf_valid;
    logic         outstanding;
    logic         free_slot;
    logic [CNT_W-1:0] buf_count;

    // a slot is reserved for every request from issue until its response lands
    assign outstanding = (state != IDLE);
    assign free_slot   = (buf_count + CNT_W'(outstanding)) < CNT_W'(FETCH_DEPTH);

    always_comb begin
        state_next = state;
        push       = 1'b0;
        advance    = 1'b0;
        push_data  = '{instr: imem_rdata, pc: imem_addr, fault: imem_err};
        case (state)
            IDLE: begin
                if (!flush && free_slot) begin
                    if (pc_in[1:0] == 2'b00) begin
                        state_next = REQ;
                    end else begin
                        push      = 1'b1;
                        advance   = 1'b1;
                        push_data = '{instr: NOP, pc: pc_in, fault: 1'b1};
                    end
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    state_next = flush ? DROP : WAIT;
                    advance    = !flush;
                end else if (flush) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = IDLE;
                    push       = !flush;
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state    <= state_next;
            imem_req <= (state_next == REQ);
            if (state == IDLE && state_next == REQ) imem_addr <= pc_in;
        end
    end

    assign pc_advance = advance && reset;
    assign pop        = buf_valid && instr_ready;

    fetch_buffer #(.DEPTH(FETCH_DEPTH)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .head_valid (buf_valid),
        .count      (buf_count)
    );

    assign instr_valid = buf_valid;
    assign instr       = buf_valid ? head.instr : '0;
    assign instr_pc    = buf_valid ? head.pc    : '0;
    assign instr_fault = buf_valid && head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    fetch_unit #(.FETCH_DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_advance  (pc_advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        s_adv, s_req, s_valid, s_fault, s_rdy;
    logic [31:0] s_addr, s_instr, s_pc, s_pcin;

    logic [31:0] pc_list [1024];
    int          pc_idx;
    bit          pc_auto, mem_auto, err_on;
    int          gnt_pct, maxdly;
    bit          pend;
    logic [31:0] pend_addr;
    int          dly;
    int          adv_total;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return err_on && (a[4:2] == 3'b101);
    endfunction

    // sample at negedge, then advance one edge; PC register and memory react after the edge
    task automatic cyc();
        @(negedge clk);
        s_adv = pc_advance; s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
        s_instr = instr; s_pc = instr_pc; s_fault = instr_fault; s_rdy = instr_ready; s_pcin = pc_in;
        if (s_adv) adv_total++;
        @(posedge clk);
        #1;
        if (pc_auto && s_adv && pc_idx < 1023) begin
            pc_idx++;
            pc_in = pc_list[pc_idx];
        end
        if (mem_auto) begin
            if (imem_rvalid) pend = 0;
            if (s_req && imem_gnt) begin
                pend = 1; pend_addr = s_addr; dly = $urandom_range(0, maxdly);
            end
            imem_gnt = 0; imem_rvalid = 0; imem_err = 0; imem_rdata = 0;
            if (pend) begin
                if (dly == 0) begin
                    imem_rvalid = 1; imem_rdata = mem_word(pend_addr); imem_err = mem_err(pend_addr);
                end else begin
                    dly--;
                end
            end
            if (imem_req && !pend) imem_gnt = ($urandom_range(0, 99) < gnt_pct);
        end
    endtask

    task automatic do_reset();
        reset = 0; flush = 0; instr_ready = 0; imem_gnt = 0; imem_rvalid = 0;
        imem_err = 0; imem_rdata = 0; pc_auto = 0; mem_auto = 0; pend = 0; pc_in = 0;
        repeat (2) cyc();
        adv_total = 0;
    endtask

    task automatic test_reset();
        do_reset();
        pc_in = 32'h0000_0104; imem_gnt = 1; imem_rvalid = 1; imem_rdata = $urandom(); instr_ready = 1;
        repeat (3) cyc();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h want 0", s_req); end
        checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", s_addr); end
        checks++; if (s_adv !== 1'b0) begin errors++; $display("FAIL reset_adv got %0h want 0", s_adv); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", s_valid); end
        checks++; if ({s_instr, s_pc, s_fault} !== 65'h0) begin errors++; $display("FAIL reset_head got %h %h %0h want 0", s_instr, s_pc, s_fault); end
        imem_gnt = 0; imem_rvalid = 0; instr_ready = 0; pc_in = 32'h100; reset = 1;
        cyc();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL first_idle_req got %0h want 0", s_req); end
        cyc();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL first_req got %0h %h want 1 00000100", s_req, s_addr); end
    endtask

    task automatic test_basic();
        do_reset();
        pc_in = 0; instr_ready = 1; reset = 1;
        cyc();
        imem_gnt = 1;
        cyc();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h0 || s_adv !== 1'b1) begin errors++; $display("FAIL basic_gnt got req=%0h addr=%h adv=%0h want 1 0 1", s_req, s_addr, s_adv); end
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00500093; pc_in = 32'h4;
        cyc();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %0h want 0", s_valid); end
        imem_rvalid = 0;
        cyc();
        checks++; if (s_valid !== 1'b1 || s_instr !== 32'h00500093 || s_pc !== 32'h0 || s_fault !== 1'b0)
            begin errors++; $display("FAIL basic_head got v=%0h %h %h f=%0h want 1 00500093 0 0", s_valid, s_instr, s_pc, s_fault); end
        repeat (2) cyc();
        checks++; if (adv_total !== 1) begin errors++; $display("FAIL basic_adv_count got %0d want 1", adv_total); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 1024; k++) pc_list[k] = 32'(k * 4);
        pc_idx = 0; pc_in = 0; pc_auto = 1; mem_auto = 1; gnt_pct = 100; maxdly = 0; err_on = 0;
        instr_ready = 0; reset = 1;
        repeat (20) cyc();
        checks++; if (adv_total !== 2) begin errors++; $display("FAIL bp_adv got %0d want 2", adv_total); end
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== mem_word(0)) begin errors++; $display("FAIL bp_head got v=%0h %h %h want 1 %h 0", s_valid, s_instr, s_pc, mem_word(0)); end
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL bp_no_req got %0h want 0", s_req); end
        instr_ready = 1;
        cyc();
        instr_ready = 0;
        repeat (10) cyc();
        checks++; if (adv_total !== 3) begin errors++; $display("FAIL bp_adv_after_pop got %0d want 3", adv_total); end
        checks++; if (s_pc !== 32'h4 || s_req !== 1'b0) begin errors++; $display("FAIL bp_head2 got pc=%h req=%0h want 4 0", s_pc, s_req); end
    endtask

    task automatic test_misaligned();
        bit req_seen = 0;
        do_reset();
        pc_in = 32'h6; reset = 1;
        cyc();
        checks++; if (s_adv !== 1'b1 || s_req !== 1'b0) begin errors++; $display("FAIL mis_adv got adv=%0h req=%0h want 1 0", s_adv, s_req); end
        cyc();
        checks++; if (s_valid !== 1'b1 || s_instr !== 32'h13 || s_pc !== 32'h6 || s_fault !== 1'b1)
            begin errors++; $display("FAIL mis_head got v=%0h %h %h f=%0h want 1 00000013 6 1", s_valid, s_instr, s_pc, s_fault); end
        repeat (4) begin cyc(); req_seen |= s_req; end
        checks++; if (req_seen !== 1'b0 || adv_total !== 2) begin errors++; $display("FAIL mis_fill got req=%0h adv=%0d want 0 2", req_seen, adv_total); end
    endtask

    task automatic test_flush_wait();
        bit valid_seen = 0;
        bit req_seen = 0;
        do_reset();
        pc_in = 32'h10; instr_ready = 1; reset = 1;
        cyc();
        imem_gnt = 1;
        cyc();
        imem_gnt = 0; flush = 1;
        cyc();
        checks++; if (s_adv !== 1'b0) begin errors++; $display("FAIL fw_adv got %0h want 0", s_adv); end
        flush = 0;
        cyc();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL fw_drop_req got %0h want 0", s_req); end
        imem_rvalid = 1; imem_rdata = 32'hDEADBEEF;
        cyc();
        checks++; if (s_req !== 1'b0 || s_adv !== 1'b0) begin errors++; $display("FAIL fw_drop_rv got req=%0h adv=%0h want 0 0", s_req, s_adv); end
        imem_rvalid = 0;
        repeat (6) begin cyc(); valid_seen |= s_valid; req_seen |= s_req; end
        checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL fw_valid got %0h want 0", valid_seen); end
        checks++; if (req_seen !== 1'b1 || s_addr !== 32'h10) begin errors++; $display("FAIL fw_refetch got req=%0h addr=%h want 1 00000010", req_seen, s_addr); end
    endtask

    task automatic test_flush_misc();
        do_reset();
        pc_in = 32'h40; reset = 1;
        cyc();
        flush = 1;
        cyc();
        flush = 0;
        cyc();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL fr_req_drop got %0h want 0", s_req); end
        imem_gnt = 1;
        cyc();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678; flush = 1;
        cyc();
        imem_rvalid = 0; flush = 0;
        cyc();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL fwr_valid got %0h want 0", s_valid); end
        cyc();
        checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL fwr_idle got req=%0h want 1", s_req); end
        do_reset();
        pc_in = 32'h42; reset = 1;
        cyc();
        flush = 1;
        cyc();
        checks++; if (s_adv !== 1'b0 || s_valid !== 1'b1) begin errors++; $display("FAIL fb_flush got adv=%0h v=%0h want 0 1", s_adv, s_valid); end
        flush = 0;
        cyc();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL fb_empty got %0h want 0", s_valid); end
    endtask

    task automatic test_bus_error();
        logic [31:0] d;
        do_reset();
        pc_in = 32'h20; reset = 1;
        cyc();
        imem_gnt = 1;
        cyc();
        d = $urandom();
        imem_gnt = 0; imem_rvalid = 1; imem_err = 1; imem_rdata = d; pc_in = 32'h24;
        cyc();
        imem_rvalid = 0; imem_err = 0;
        cyc();
        checks++; if (s_valid !== 1'b1 || s_fault !== 1'b1 || s_pc !== 32'h20 || s_instr !== d)
            begin errors++; $display("FAIL buserr got v=%0h f=%0h pc=%h i=%h want 1 1 00000020 %h", s_valid, s_fault, s_pc, s_instr, d); end
    endtask

    task automatic test_reset_wait();
        bit valid_seen = 0;
        do_reset();
        pc_in = 32'h30; instr_ready = 1; reset = 1;
        cyc();
        imem_gnt = 1;
        cyc();
        imem_gnt = 0; pc_in = 32'h34; reset = 0;
        cyc();
        imem_rvalid = 1; imem_rdata = 32'hCAFEF00D;
        cyc();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rw_req got %0h want 0", s_req); end
        reset = 1; pc_in = 32'h40;
        cyc();
        checks++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL rw_idle got req=%0h v=%0h want 0 0", s_req, s_valid); end
        imem_rvalid = 0;
        cyc();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h40) begin errors++; $display("FAIL rw_fresh got req=%0h addr=%h want 1 00000040", s_req, s_addr); end
        repeat (3) begin cyc(); valid_seen |= s_valid; end
        checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL rw_valid got %0h want 0", valid_seen); end
    endtask

    // the popped stream must be exactly the PC sequence, each word derived from its address
    task automatic test_random();
        int pops = 0;
        logic [31:0] p, exp_i;
        logic exp_f;
        do_reset();
        for (int k = 0; k < 1024; k++) begin
            p = 32'($urandom_range(0, 32'h0000FFFF));
            if ($urandom_range(0, 7) != 0) p[1:0] = 2'b00;
            pc_list[k] = p;
        end
        pc_idx = 0; pc_in = pc_list[0]; pc_auto = 1; mem_auto = 1;
        gnt_pct = 50; maxdly = 3; err_on = 1; reset = 1;
        for (int c = 0; c < 800; c++) begin
            instr_ready = ($urandom_range(0, 99) < 60);
            cyc();
            if (s_valid && s_rdy) begin
                p = pc_list[pops];
                if (p[1:0] != 2'b00) begin exp_i = 32'h13; exp_f = 1'b1; end
                else begin exp_i = mem_word(p); exp_f = mem_err(p); end
                checks++;
                if (s_pc !== p || s_instr !== exp_i || s_fault !== exp_f) begin
                    errors++;
                    $display("FAIL rnd_pop%0d got %h %h %0h want %h %h %0h", pops, s_pc, s_instr, s_fault, p, exp_i, exp_f);
                end
                pops++;
            end
            if (s_req) begin
                checks++;
                if (s_addr !== s_pcin) begin errors++; $display("FAIL rnd_addr got %h want %h", s_addr, s_pcin); end
            end
            checks++;
            if (adv_total - pops > 2 || adv_total < pops) begin errors++; $display("FAIL rnd_occupancy got %0d want 0..2", adv_total - pops); end
        end
        checks++; if (pops < 20) begin errors++; $display("FAIL rnd_progress got %0d want >=20", pops); end
    endtask

    initial begin
        adv_total = 0; pc_idx = 0; gnt_pct = 0; maxdly = 0; err_on = 0; dly = 0; pend_addr = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_misaligned();
        test_flush_wait();
        test_flush_misc();
        test_bus_error();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter FETCH_DEPTH, default 2, instruction buffer depth in entries (power of two, >= 2).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled on rising edge of clk only.
REQ-004 pc_in  in  32  current PC from the PC register.
REQ-005 pc_advance  out  1  one-cycle pulse; PC register loads pcnext only in a cycle where this is 1.
REQ-006 imem_req  out  1  instruction memory request valid.
REQ-007 imem_addr  out  32  request address, word-aligned.
REQ-008 imem_gnt  in  1  memory accepts request this cycle when imem_req=1.
REQ-009 imem_rvalid  in  1  read data valid.
REQ-010 imem_rdata  in  32  read data.
REQ-011 imem_err  in  1  bus error qualifying imem_rvalid.
REQ-012 flush  in  1  discard all buffered and in-flight fetches.
REQ-013 instr_valid  out  1  buffer head valid.
REQ-014 instr_ready  in  1  decode consumes head when instr_valid=1.
REQ-015 instr  out  32  head instruction word.
REQ-016 instr_pc  out  32  address the head was fetched from.
REQ-017 instr_fault  out  1  head carries a fetch fault (misaligned or bus error).

Function
REQ-018 FSM states IDLE, REQ, WAIT, DROP; at most one memory request outstanding.
REQ-019 IDLE -> REQ when no flush, pc_in[1:0]=0, and buffered count + outstanding < FETCH_DEPTH; imem_req=1 and imem_addr=pc_in registered on that transition.
REQ-020 REQ: imem_req, imem_addr held stable until imem_gnt=1; on gnt -> WAIT, pc_advance=1 in the gnt cycle only.
REQ-021 WAIT: on imem_rvalid push {imem_rdata, captured addr, imem_err} -> IDLE; entry visible on instr_* the following cycle.
REQ-022 Misaligned pc_in (pc_in[1:0]!=0) in IDLE with free slot: no memory request; push {32'h00000013, pc_in, fault=1}; pc_advance=1 that cycle.
REQ-023 Buffer pops when instr_valid & instr_ready; push and pop in same cycle both occur, count unchanged.
REQ-024 Pop on empty buffer: no effect; push never occurs when full (guaranteed by REQ-019 reservation).
REQ-025 Buffer pointers wrap modulo FETCH_DEPTH.
REQ-026 Flush: buffer emptied at that edge (instr_valid=0 next cycle), pc_advance=0, flush overrides same-cycle push/pop.
REQ-027 Flush in REQ without gnt -> IDLE, imem_req=0 next cycle; flush in REQ with gnt, or in WAIT without rvalid -> DROP.
REQ-028 Flush in WAIT with simultaneous rvalid: data discarded, -> IDLE.
REQ-029 DROP: imem_req=0; next imem_rvalid discarded -> IDLE; no pc_advance in DROP.
REQ-030 Best-case throughput: gnt in cycle N, rvalid N+1, instr_valid N+2.

Reset
REQ-031 While reset=0 at an edge: state IDLE, buffer empty, outstanding cleared, imem_req=0, imem_addr=0, pc_advance=0, instr_valid=0, instr=0, instr_pc=0, instr_fault=0.
REQ-032 Reset mid-transaction abandons outstanding request; any imem_rvalid after reset while IDLE is ignored.
REQ-033 First request issued at the first edge with reset=1.

Structure
REQ-034 Shared package fetch_pkg holds state enum, FETCH_DEPTH default, NOP constant 32'h00000013, buffer entry struct {instr, pc, fault}.
REQ-035 Buffer implemented as sub-module fetch_buffer (synchronous FIFO, count output).

Verification
REQ-036 pc_in=0x0, gnt same cycle as req, rvalid next cycle, rdata=0x00500093, instr_ready=1 -> instr=0x00500093, instr_pc=0x0, one pc_advance pulse.
REQ-037 instr_ready=0, zero-wait memory, pc_in stepping 0x0,0x4,0x8 -> exactly 2 entries buffered, third request not issued until one pop.
REQ-038 pc_in=0x6 -> no imem_req, instr=0x00000013, instr_pc=0x6, instr_fault=1.
REQ-039 Flush while in WAIT at addr 0x10, rvalid two cycles later with 0xDEADBEEF -> entry never appears, instr_valid stays 0.
REQ-040 imem_err=1 with rvalid at addr 0x20 -> instr_fault=1, instr_pc=0x20.
REQ-041 reset=0 during WAIT, then rvalid -> no entry, imem_req=0 during reset, fresh request at pc_in after reset=1.
